// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared constants and types for the console output arbiter
package uart_arb_pkg;
  typedef logic [7:0] uart_ch_t;
  localparam uart_ch_t CH_NL = 8'h0A;
  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;
endpackage

// File: rtl/uart_char_fifo.sv
// uart_char_fifo: circular character buffer with wrap-bit pointers and async reset
module uart_char_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  uart_ch_t               push_ch,
  input  logic                   pop,
  output uart_ch_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;
  uart_ch_t mem [DEPTH];
  ptr_t wptr, rptr;
  assign level = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = level[AW];
  assign head = mem[rptr[AW-1:0]];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + ptr_t'(1);
      if (pop && !empty) rptr <= rptr + ptr_t'(1);
    end
  always_ff @(posedge clock)
    if (push && !full) mem[wptr[AW-1:0]] <= push_ch;
endmodule

// File: rtl/uart_out_arbiter.sv
// uart_out_arbiter: line-atomic round-robin sharing of the console output channel
module uart_out_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int GAP   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [8*NREQ-1:0]      req_ch,
  output logic [NREQ-1:0]        req_ready,
  output logic                   io_uart_out_valid,
  output uart_ch_t               io_uart_out_ch,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int IW = $clog2(NREQ);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  typedef logic [IW-1:0] idx_t;
  arb_state_t state, state_n;
  idx_t owner, owner_n, rr, rr_n, sel;
  logic [NREQ-1:0] rot;
  logic hit, full, empty, xfer, pop;
  logic [GW-1:0] gap_cnt;
  uart_ch_t ch, head;
  assign rot = NREQ'({req_valid, req_valid} >> rr);
  always_comb begin
    sel = owner;
    hit = state == ARB_OWNED;
    if (state == ARB_IDLE)
      for (int k = NREQ - 1; k >= 0; k--)
        if (rot[k]) begin
          sel = idx_t'((int'(rr) + k) % NREQ);
          hit = 1'b1;
        end
  end
  assign req_ready = hit && !full ? NREQ'(1) << sel : '0;
  assign xfer = |(req_valid & req_ready);
  assign ch = req_ch[{sel, 3'b000} +: 8];
  assign pop = !empty && gap_cnt == '0;
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n = rr;
    if (xfer) begin
      state_n = ch == CH_NL ? ARB_IDLE : ARB_OWNED;
      owner_n = sel;
      rr_n = ch == CH_NL ? (sel == idx_t'(NREQ - 1) ? '0 : sel + idx_t'(1)) : rr;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ARB_IDLE;
      owner <= '0;
      rr <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr <= rr_n;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      io_uart_out_valid <= 1'b0;
      io_uart_out_ch <= '0;
      gap_cnt <= '0;
    end else begin
      io_uart_out_valid <= pop;
      if (pop) io_uart_out_ch <= head;
      gap_cnt <= pop ? GW'(GAP) : gap_cnt == '0 ? gap_cnt : gap_cnt - GW'(1);
    end
  uart_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(xfer),
    .push_ch(ch),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
endmodule
